// File: rtl/mag_pkg.sv
// rtl/mag_pkg.sv - shared state encoding and widths for the magnetron controller
package mag_pkg;

    localparam int PWR_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COOK  = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } mag_state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-second tick prescaler, holds its count while run is low
module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/magnetron_ctrl.sv
// rtl/magnetron_ctrl.sv - microwave cook timer FSM with duty-cycled magnetron and door interlock
module magnetron_ctrl
    import mag_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int TIME_W   = 12,
    parameter int PWR_MAX  = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              doorn,
    input  logic              load,
    input  logic [TIME_W-1:0] time_in,
    input  logic [PWR_W-1:0]  pwr_in,
    output logic              mag_on,
    output logic [TIME_W-1:0] time_left,
    output logic [2:0]        state,
    output logic              done
);

    localparam logic [PWR_W-1:0] PWR_MAX_V = PWR_W'(PWR_MAX);
    localparam logic [PWR_W-1:0] DUTY_LAST = PWR_W'(PWR_MAX - 1);

    mag_state_t        state_q, state_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [PWR_W-1:0]  power_q, power_d;
    logic [PWR_W-1:0]  duty_q, duty_d;
    logic              done_q, done_d;
    logic              en_q, en_d;
    logic              start_h, stop_h, clear_h;
    logic              start_p, stop_p, clear_p;
    logic              run, clr, tick;

    assign start_p = start_h & ~startn;
    assign stop_p  = stop_h  & ~stopn;
    assign clear_p = clear_h & ~clearn;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .resetn (resetn),
        .run    (run),
        .clr    (clr),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        power_d = power_q;
        duty_d  = duty_q;
        run     = 1'b0;
        clr     = 1'b0;
        if (clear_p) begin
            state_d = IDLE;
            time_d  = '0;
            power_d = '0;
            duty_d  = '0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_p && (time_q != '0) && !doorn) begin
                        state_d = COOK;
                        duty_d  = '0;
                        clr     = 1'b1;
                    end else if (load) begin
                        time_d  = time_in;
                        power_d = (pwr_in > PWR_MAX_V) ? PWR_MAX_V : pwr_in;
                    end
                end
                COOK: begin
                    if (doorn || stop_p) begin
                        state_d = PAUSE;
                    end else begin
                        run = 1'b1;
                        if (tick) begin
                            time_d = time_q - TIME_W'(1);
                            duty_d = (duty_q == DUTY_LAST) ? '0 : duty_q + PWR_W'(1);
                            if (time_q == TIME_W'(1)) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    // An open door outranks both buttons, so nothing moves until it closes
                    if (!doorn) begin
                        if (stop_p) begin
                            state_d = IDLE;
                            time_d  = '0;
                        end else if (start_p) begin
                            state_d = COOK;
                        end
                    end
                end
                DONE: begin
                    if (doorn || stop_p) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        done_d = (state_d == DONE) && (state_q != DONE);
        en_d   = (state_d == COOK) && (duty_d < power_d);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            time_q  <= '0;
            power_q <= '0;
            duty_q  <= '0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            start_h <= 1'b1;
            stop_h  <= 1'b1;
            clear_h <= 1'b1;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            power_q <= power_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
            en_q    <= en_d;
            start_h <= startn;
            stop_h  <= stopn;
            clear_h <= clearn;
        end
    end

    // The door gates the registered enable directly so opening it cuts power this cycle
    assign mag_on    = en_q & ~doorn;
    assign time_left = time_q;
    assign state     = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// tb/tb_magnetron_ctrl.sv - self-checking bench for magnetron_ctrl
module tb_magnetron_ctrl;

    localparam int TD = 4;
    localparam int PM = 10;
    localparam int TW = 12;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          startn = 1'b1;
    logic          stopn = 1'b1;
    logic          clearn = 1'b1;
    logic          doorn = 1'b0;
    logic          load = 1'b0;
    logic [TW-1:0] time_in = '0;
    logic [3:0]    pwr_in = '0;
    logic          mag_on;
    logic [TW-1:0] time_left;
    logic [2:0]    state;
    logic          done;

    magnetron_ctrl #(.TICK_DIV(TD), .TIME_W(TW), .PWR_MAX(PM)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .startn    (startn),
        .stopn     (stopn),
        .clearn    (clearn),
        .doorn     (doorn),
        .load      (load),
        .time_in   (time_in),
        .pwr_in    (pwr_in),
        .mag_on    (mag_on),
        .time_left (time_left),
        .state     (state),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: time loaded at start plus cycles spent cooking; ticks and duty derive from that
    int m_state, m_time, m_pwr, m_cyc;
    bit m_done, h_start, h_stop, h_clear;

    function automatic int exp_time();
        return m_time - m_cyc / TD;
    endfunction

    function automatic bit exp_mag();
        return (m_state == 1) && (((m_cyc / TD) % PM) < m_pwr) && !doorn;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ps, pp, pc;
        int ns;
        if (!resetn) begin
            m_state = 0; m_time = 0; m_pwr = 0; m_cyc = 0; m_done = 0;
            h_start = 1; h_stop = 1; h_clear = 1;
            return;
        end
        ps = h_start && !startn;
        pp = h_stop && !stopn;
        pc = h_clear && !clearn;
        h_start = startn; h_stop = stopn; h_clear = clearn;
        ns = m_state;
        if (pc) begin
            ns = 0; m_time = 0; m_pwr = 0; m_cyc = 0;
        end else begin
            case (m_state)
                0: if (ps && exp_time() != 0 && !doorn) begin
                       ns = 1; m_time = exp_time(); m_cyc = 0;
                   end else if (load) begin
                       m_time = int'(time_in); m_cyc = 0;
                       m_pwr = (int'(pwr_in) > PM) ? PM : int'(pwr_in);
                   end
                1: if (doorn || pp) ns = 2;
                   else begin
                       m_cyc++;
                       if (m_cyc % TD == 0 && exp_time() == 0) ns = 3;
                   end
                2: if (!doorn) begin
                       if (pp) begin ns = 0; m_time = 0; m_cyc = 0; end
                       else if (ps) ns = 1;
                   end
                3: if (doorn || pp) begin ns = 0; m_time = 0; m_cyc = 0; end
                default: ns = 0;
            endcase
        end
        m_done = (ns == 3) && (m_state != 3);
        m_state = ns;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_state", int'(state), m_state);
        chk("m_time_left", int'(time_left), exp_time());
        chk("m_mag_on", int'(mag_on), int'(exp_mag()));
        chk("m_done", int'(done), int'(m_done));
    endtask

    task automatic idle_inputs();
        startn = 1; stopn = 1; clearn = 1; doorn = 0; load = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        step(); step();
        resetn = 1;
    endtask

    task automatic load_and_start(input int t, input int p);
        load = 1; time_in = TW'(t); pwr_in = 4'(p);
        step();
        load = 0;
        startn = 0;
        step();
        startn = 1;
    endtask

    typedef struct {
        logic          startn, stopn, clearn, doorn, load;
        logic [TW-1:0] time_in;
        logic [3:0]    pwr_in;
        int            e_state, e_time;
        logic          e_mag, e_done;
    } vec_t;

    vec_t tbl[19];
    int   ons, dones;

    initial begin
        tbl[0]  = '{1, 1, 1, 0, 1, 5, 12, 0, 5, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 0, 0, 0,  0, 5, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 0, 0, 0,  0, 5, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[5]  = '{1, 1, 1, 0, 1, 2, 0,  0, 2, 0, 0};
        tbl[6]  = '{0, 1, 1, 0, 0, 0, 0,  1, 2, 0, 0};
        tbl[7]  = '{0, 1, 1, 0, 0, 0, 0,  1, 2, 0, 0};
        tbl[8]  = '{1, 1, 1, 0, 0, 0, 0,  1, 2, 0, 0};
        tbl[9]  = '{1, 1, 1, 0, 1, 9, 5,  1, 2, 0, 0};
        tbl[10] = '{1, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0};
        tbl[11] = '{1, 0, 1, 0, 0, 0, 0,  2, 1, 0, 0};
        tbl[12] = '{0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0};
        tbl[13] = '{1, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0};
        tbl[14] = '{1, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0};
        tbl[15] = '{1, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0};
        tbl[16] = '{1, 1, 1, 0, 0, 0, 0,  3, 0, 0, 1};
        tbl[17] = '{1, 1, 1, 0, 0, 0, 0,  3, 0, 0, 0};
        tbl[18] = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0};

        do_reset();
        chk("rst_state", int'(state), 0);
        chk("rst_time", int'(time_left), 0);
        chk("rst_mag", int'(mag_on), 0);
        chk("rst_done", int'(done), 0);

        for (int i = 0; i < 19; i++) begin
            startn = tbl[i].startn; stopn = tbl[i].stopn; clearn = tbl[i].clearn;
            doorn = tbl[i].doorn; load = tbl[i].load;
            time_in = tbl[i].time_in; pwr_in = tbl[i].pwr_in;
            step();
            chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].e_state);
            chk($sformatf("tbl%0d_time", i), int'(time_left), tbl[i].e_time);
            chk($sformatf("tbl%0d_mag", i), int'(mag_on), int'(tbl[i].e_mag));
            chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
        end
        idle_inputs();

        // Full power, 3 s: continuous magnetron, one done pulse
        do_reset();
        load_and_start(3, 10);
        chk("full_t3", int'(time_left), 3);
        ons = 0; dones = 0;
        for (int k = 0; k < 14; k++) begin
            if (k == 4)  chk("full_t2", int'(time_left), 2);
            if (k == 8)  chk("full_t1", int'(time_left), 1);
            if (k == 12) chk("full_t0", int'(time_left), 0);
            if (k < 12)  chk("full_mag", int'(mag_on), 1);
            ons += int'(mag_on);
            dones += int'(done);
            step();
        end
        chk("full_on_cycles", ons, 12);
        chk("full_done_pulses", dones, 1);
        chk("full_state_done", int'(state), 3);

        // Power 3: 12 of every 40 cycles on
        do_reset();
        load_and_start(20, 3);
        ons = 0;
        for (int k = 0; k < 80; k++) begin
            ons += int'(mag_on);
            if (k == 39) chk("duty_win1", ons, 12);
            step();
        end
        chk("duty_win2", ons, 24);

        // Door opened mid-cook
        do_reset();
        load_and_start(10, 10);
        repeat (5) step();
        doorn = 1;
        #1;
        chk("door_mag_now", int'(mag_on), 0);
        chk("door_still_cook", int'(state), 1);
        step();
        chk("door_pause", int'(state), 2);
        chk("door_time", int'(time_left), 9);
        repeat (8) step();
        chk("door_frozen", int'(time_left), 9);
        doorn = 0; startn = 0;
        step();
        startn = 1;
        chk("door_resume", int'(state), 1);
        step(); step();
        chk("door_resume_t9", int'(time_left), 9);
        step();
        chk("door_resume_t8", int'(time_left), 8);

        // Clear and start together in PAUSE, then double stop
        doorn = 1; step(); doorn = 0;
        clearn = 0; startn = 0;
        step();
        clearn = 1; startn = 1;
        chk("clr_start_state", int'(state), 0);
        chk("clr_start_time", int'(time_left), 0);
        load_and_start(6, 5);
        stopn = 0; step(); stopn = 1;
        chk("stop1_pause", int'(state), 2);
        step();
        stopn = 0; step(); stopn = 1;
        chk("stop2_idle", int'(state), 0);
        chk("stop2_time", int'(time_left), 0);

        // Reset mid-cook with start held through release
        load_and_start(5, 10);
        repeat (3) step();
        resetn = 0; startn = 0;
        step();
        chk("mrst_state", int'(state), 0);
        chk("mrst_time", int'(time_left), 0);
        chk("mrst_mag", int'(mag_on), 0);
        chk("mrst_done", int'(done), 0);
        resetn = 1;
        step();
        load = 1; time_in = 5; pwr_in = 4;
        step();
        load = 0;
        repeat (4) step();
        chk("held_start_idle", int'(state), 0);
        chk("held_start_time", int'(time_left), 5);
        startn = 1;

        // Randomized run against the model
        idle_inputs();
        for (int k = 0; k < 4000; k++) begin
            resetn  = ($urandom_range(0, 499) != 0);
            startn  = ($urandom_range(0, 9) != 0);
            stopn   = ($urandom_range(0, 29) != 0);
            clearn  = ($urandom_range(0, 99) != 0);
            doorn   = ($urandom_range(0, 24) == 0);
            load    = ($urandom_range(0, 9) == 0);
            time_in = TW'($urandom_range(0, 6));
            pwr_in  = 4'($urandom_range(0, 15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
